// File: rtl/room_temp_model.sv
// room_temp_model: thermal plant that ramps under heat/cool commands and drifts toward ambient
module room_temp_model #(
  parameter logic [7:0] AMBIENT   = 8'd20,
  parameter int         RATE_DIV  = 1000,
  parameter int         DRIFT_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red,
  input  logic       blue,
  input  logic       load,
  input  logic [7:0] load_temp,
  output logic [7:0] current_temp,
  output logic       tick,
  output logic       fault,
  output logic       sat
);
  typedef enum logic [1:0] {DRIFT, HEAT, COOL, FAULT} state_t;
  localparam int PW = RATE_DIV > 1 ? $clog2(RATE_DIV) : 1;
  localparam int DW = DRIFT_DIV > 1 ? $clog2(DRIFT_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(RATE_DIV - 1);
  localparam logic [DW-1:0] D_MAX = DW'(DRIFT_DIV - 1);
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] drift_q, drift_d;
  logic [7:0] temp_q, temp_d, toward;
  // next-state: command decode, prescaler, drift counter and saturating temperature update
  always_comb begin
    state_d = (red & blue) ? FAULT : red ? HEAT : blue ? COOL : DRIFT;
    tick    = presc_q == P_MAX;
    presc_d = (load | tick) ? '0 : presc_q + PW'(1);
    drift_d = (load || state_q != DRIFT) ? '0 :
              !tick ? drift_q :
              drift_q == D_MAX ? '0 : drift_q + DW'(1);
    toward  = temp_q < AMBIENT ? temp_q + 8'd1 :
              temp_q > AMBIENT ? temp_q - 8'd1 : temp_q;
    temp_d  = load ? load_temp :
              !tick ? temp_q :
              state_q == HEAT ? (temp_q == 8'hff ? temp_q : temp_q + 8'd1) :
              state_q == COOL ? (temp_q == 8'h00 ? temp_q : temp_q - 8'd1) :
              (state_q == DRIFT && drift_q == D_MAX) ? toward : temp_q;
  end
  // plant registers; reset lands at ambient in DRIFT with counters cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DRIFT;
      presc_q <= '0;
      drift_q <= '0;
      temp_q  <= AMBIENT;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      drift_q <= drift_d;
      temp_q  <= temp_d;
    end
  end
  assign current_temp = temp_q;
  assign fault = state_q == FAULT;
  assign sat = temp_q == 8'h00 || temp_q == 8'hff;
endmodule

// File: tb/tb_room_temp_model.sv
// tb_room_temp_model: directed scoreboard bench for the thermal plant
module tb_room_temp_model;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, red_m = 1'b0, blue_m = 1'b0, loop_en = 1'b0;
  logic red, blue, tick, fault, sat;
  logic [7:0] load_temp = 8'd0, current_temp;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {
    int cyc;
    string nm;
    int lo;
    int hi;
    int t;
    int f;
    int s;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  event sample_ev;

  room_temp_model #(.AMBIENT(8'd20), .RATE_DIV(4), .DRIFT_DIV(2)) dut (
    .clk(clk), .rst(rst), .red(red), .blue(blue), .load(load), .load_temp(load_temp),
    .current_temp(current_temp), .tick(tick), .fault(fault), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // thermostat comparator with set_temp = 24 closes the loop in the last scenario
  assign red  = loop_en ? current_temp < 8'd24 : red_m;
  assign blue = loop_en ? current_temp > 8'd24 : blue_m;

  task automatic expect_now(input string nm, input int lo, input int hi, input int t, input int f, input int s);
    exp_t x;
    x.cyc = cyc; x.nm = nm; x.lo = lo; x.hi = hi; x.t = t; x.f = f; x.s = s;
    sb.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit bad(input int want, input logic act);
    return want >= 0 && act !== want[0];
  endfunction

  // monitor: pops every expectation due by now and compares against the live outputs
  always begin
    @(negedge clk or sample_ev);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || $isunknown({current_temp, tick, fault, sat}) ||
          int'(current_temp) < e.lo || int'(current_temp) > e.hi ||
          bad(e.t, tick) || bad(e.f, fault) || bad(e.s, sat)) begin
        errors++;
        $display("FAIL %s @cyc %0d (due %0d): got temp=%0d tick=%b fault=%b sat=%b, want temp=%0d..%0d tick=%0d fault=%0d sat=%0d",
                 e.nm, cyc, e.cyc, current_temp, tick, fault, sat, e.lo, e.hi, e.t, e.f, e.s);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    // reset and idle: tick on cycles 4, 8, 12, temperature stays at ambient
    step(2);
    rst = 1'b0;
    expect_now("reset", 20, 20, 0, 0, 0);
    for (int i = 2; i <= 12; i++) begin
      step(1);
      expect_now("idle", 20, 20, (i % 4 == 0) ? 1 : 0, 0, 0);
    end
    // heat 40 cycles from 20 -> 30, then drift back one degree per 8 cycles
    load = 1'b1; load_temp = 8'd20; red_m = 1'b1;
    step(1);
    load = 1'b0;
    expect_now("heat_start", 20, 20, 0, 0, 0);
    step(19);
    expect_now("heat_mid", 24, 24, 1, 0, 0);
    step(20);
    expect_now("heat_last_tick", 29, 29, 1, 0, 0);
    red_m = 1'b0;
    step(1);
    expect_now("heat_done", 30, 30, 0, 0, 0);
    step(7);
    expect_now("drift_first_wait", 30, 30, 1, 0, 0);
    step(1);
    expect_now("drift_first_step", 29, 29, 0, 0, 0);
    step(71);
    expect_now("drift_near_amb", 21, 21, 1, 0, 0);
    step(1);
    expect_now("drift_at_amb", 20, 20, 0, 0, 0);
    step(16);
    expect_now("drift_hold_amb", 20, 20, -1, 0, 0);
    // saturation at both ends
    load = 1'b1; load_temp = 8'd254; red_m = 1'b1;
    step(1);
    load = 1'b0;
    expect_now("sat_load_254", 254, 254, 0, 0, 0);
    step(3);
    expect_now("sat_pre_tick", 254, 254, 1, 0, 0);
    step(1);
    expect_now("sat_hi", 255, 255, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(4);
      expect_now("sat_hi_hold", 255, 255, 0, 0, 1);
    end
    load = 1'b1; load_temp = 8'd1; red_m = 1'b0; blue_m = 1'b1;
    step(1);
    load = 1'b0;
    expect_now("cool_load_1", 1, 1, 0, 0, 0);
    step(4);
    expect_now("sat_lo", 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(4);
      expect_now("sat_lo_hold", 0, 0, 0, 0, 1);
    end
    // both commands: fault holds temperature, release resumes drift
    load = 1'b1; load_temp = 8'd25; red_m = 1'b1;
    step(1);
    load = 1'b0;
    expect_now("fault_on", 25, 25, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(4);
      expect_now("fault_hold", 25, 25, 0, 1, 0);
    end
    red_m = 1'b0; blue_m = 1'b0;
    step(1);
    expect_now("fault_off", 25, 25, 0, 0, 0);
    step(6);
    expect_now("fault_drift_wait", 25, 25, 1, 0, 0);
    step(1);
    expect_now("fault_drift_step", 24, 24, 0, 0, 0);
    // load coinciding with a tick while heating: no step, prescaler restarts
    red_m = 1'b1;
    step(3);
    expect_now("load_tick_pre", 24, 24, 1, 0, 0);
    load = 1'b1; load_temp = 8'd100;
    step(1);
    load = 1'b0;
    expect_now("load_on_tick", 100, 100, 0, 0, 0);
    step(1);
    expect_now("load_tick_c2", 100, 100, 0, 0, 0);
    step(1);
    expect_now("load_tick_c3", 100, 100, 0, 0, 0);
    step(1);
    expect_now("load_next_tick", 100, 100, 1, 0, 0);
    step(1);
    expect_now("load_heat_step", 101, 101, 0, 0, 0);
    // ramp to 27, asynchronous reset mid-ramp, then closed loop at set_temp 24
    load = 1'b1; load_temp = 8'd20;
    step(1);
    load = 1'b0;
    step(28);
    expect_now("ramp_27", 27, 27, 0, 0, 0);
    ->sample_ev;
    #1;
    rst = 1'b1;
    #1;
    expect_now("rst_async", 20, 20, 0, 0, 0);
    ->sample_ev;
    step(2);
    rst = 1'b0; red_m = 1'b0; loop_en = 1'b1;
    expect_now("rst_release", 20, 20, 0, 0, 0);
    step(15);
    expect_now("loop_pre_24", 23, 23, 1, 0, 0);
    step(1);
    expect_now("loop_reach_24", 24, 24, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      step(1);
      expect_now("loop_band", 23, 25, -1, 0, 0);
    end
    step(2);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/room_temp_model.md
# room_temp_model

Behavioural thermal plant that closes the loop around the thermostat comparator. It consumes the `red` (heat) and `blue` (cool) commands and produces the 8-bit `current_temp` the thermostat compares against `set_temp`. Temperature ramps one degree per rate tick while heating or cooling and drifts toward ambient when idle. It supports a synchronous preload for test and demo scenarios.

## Interface
- `AMBIENT`, default 8'd20: ambient temperature; reset value; drift target.
- `RATE_DIV`, default 1000: clocks per rate tick; legal range ≥ 2.
- `DRIFT_DIV`, default 4: rate ticks per one-degree drift step; legal range ≥ 1.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `red`, input, 1: heat command from the controller.
- `blue`, input, 1: cool command from the controller.
- `load`, input, 1: synchronous preload strobe.
- `load_temp`, input, 8: preload value, unsigned.
- `current_temp`, output, 8: registered plant temperature, unsigned.
- `tick`, output, 1: one-cycle pulse while the prescaler equals `RATE_DIV-1`.
- `fault`, output, 1: high while the state is FAULT.
- `sat`, output, 1: high while `current_temp` is 0 or 255.

## Operation
- States: DRIFT, HEAT, COOL, FAULT. The state is registered every clock from the `red`/`blue` sampled at that edge:
  - `red` & !`blue` → HEAT
  - `blue` & !`red` → COOL
  - neither → DRIFT
  - both → FAULT
- Any state can transition to any other state on any edge. There is no hysteresis.
- Prescaler counts 0..`RATE_DIV-1` and wraps to 0. `tick` is decoded from the prescaler value.
- On an edge where `tick`=1, the update uses the state held before that edge:
  - HEAT: `current_temp`+1, saturating at 255.
  - COOL: `current_temp`−1, saturating at 0.
  - DRIFT: if the drift counter equals `DRIFT_DIV-1`, step `current_temp` one degree toward `AMBIENT` (no change if equal) and clear the counter; otherwise increment the counter.
  - FAULT: `current_temp` held.
- The drift counter clears on any edge where the state is not DRIFT. It therefore restarts from 0 when DRIFT is re-entered.
- `load`=1 has the highest priority:
  - `current_temp` ← `load_temp`.
  - Prescaler and drift counter clear to 0.
  - The state register still updates normally.
  - No tick update is applied on that edge.
- Arithmetic is 8-bit unsigned. Saturation is done by explicit compare, never by wrap: 255+1 stays 255 and 0−1 stays 0.
- Reset (asynchronous, any time, including mid-ramp) sets:
  - `current_temp`=`AMBIENT`, state=DRIFT.
  - Prescaler=0, drift counter=0.
  - `tick`=0, `fault`=0, `sat`=(`AMBIENT` is 0 or 255).

## Timing
- Command latency: `red`/`blue` sampled at edge k sets the state after edge k. The first temperature effect occurs at the next tick edge after that.
- Tick period: first `tick` is high during the `RATE_DIV`th cycle after reset release. After that it is high for one cycle every `RATE_DIV` cycles.
- Slope:
  - HEAT/COOL: 1 degree per `RATE_DIV` clocks.
  - DRIFT: 1 degree per `RATE_DIV`×`DRIFT_DIV` clocks.
- `fault` and `sat` are combinational from registered state/temperature, so they are valid in the same cycle the register changes.
- If `load` coincides with `tick`, `load` wins. The next tick then occurs `RATE_DIV` cycles later.
- A command change on the same edge as a tick: the update uses the old state, and the new state takes effect from the next tick.

## Test plan
The bench uses `RATE_DIV`=4, `DRIFT_DIV`=2, `AMBIENT`=20.

1. Reset, then idle for 12 cycles → `current_temp`=20, `fault`=0, `sat`=0, `tick` high on cycles 4, 8 and 12.
2. `red`=1 held for 40 cycles from 20 → exactly 10 increments, `current_temp`=30. Then drop `red` → `current_temp` steps back down by 1 every 8 cycles, reaching 20 after 80 cycles, then holds at 20.
3. `load` with `load_temp`=254, `red`=1 → 255 after the first tick and holds at 255 for 5 more ticks, `sat`=1. Then `load` with `load_temp`=1, `blue`=1 → 0 after the first tick and holds at 0, `sat`=1.
4. `red`=`blue`=1 with `current_temp`=25 → `fault`=1 one edge later and temp held at 25 across 4 ticks. Release both → `fault`=0 on the next edge and drift resumes.
5. `load` asserted on a tick cycle with `load_temp`=100 → `current_temp`=100 with no tick step applied, and the next `tick` arrives 4 cycles later.
6. `rst` pulsed mid-ramp at `current_temp`=27 → immediately (no clock edge) `current_temp`=20 and `fault`=0. Closed loop against the thermostat with `set_temp`=24 → `current_temp` reaches 24 and stays within 23..25.
